// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and defaults for the memory port arbiter
package mips_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    EXT   = 2'd2
  } arb_state_t;

  // Identifies which requester owns an access; also used as the read-return tag.
  typedef enum logic [1:0] {
    P_NONE = 2'd0,
    P_DM   = 2'd1,
    P_IF   = 2'd2,
    P_EXT  = 2'd3
  } port_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mips_pkg::MEM_ADDR_W,
  parameter int DATA_W = mips_pkg::MEM_DATA_W
);
  logic              core_halted;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters plus the memory array.
  modport master (
    output core_halted, dm_req, dm_we, dm_addr, dm_wdata, if_req, if_addr,
           ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
    input  dm_gnt, dm_rvalid, if_gnt, if_rvalid, ext_gnt, ext_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // The arbiter itself.
  modport slave (
    input  core_halted, dm_req, dm_we, dm_addr, dm_wdata, if_req, if_addr,
           ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
    output dm_gnt, dm_rvalid, if_gnt, if_rvalid, ext_gnt, ext_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_prio_pick.sv
// rtl/mem_port_arbiter_prio_pick.sv - two-input fixed-priority picker with low-side override
module prio_pick (
  input  logic       hi_req,
  input  logic       lo_req,
  input  logic       lo_override,
  output logic [1:0] pick          // one-hot: [1]=hi, [0]=lo
);

  // High side wins unless the override lets a waiting low side jump ahead.
  always_comb begin
    pick = 2'b00;
    if (lo_override && lo_req) begin
      pick = 2'b01;
    end else if (hi_req) begin
      pick = 2'b10;
    end else if (lo_req) begin
      pick = 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for data, fetch and loader ports
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = 3
) (
  input logic               clk1,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int              SC_W   = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  arb_state_t        state;
  arb_state_t        state_nx;
  port_id_t          gnt_nx;
  port_id_t          gnt_port;
  port_id_t          rd_tag;
  logic [SC_W-1:0]   starve_cnt;
  logic              starved;
  logic [1:0]        pick;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  assign starved = (starve_cnt == SC_MAX);

  prio_pick u_prio_pick (
    .hi_req      (bus.dm_req),
    .lo_req      (bus.if_req),
    .lo_override (starved),
    .pick        (pick)
  );

  // State register.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: halting passes through one DRAIN cycle so the last read returns first.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (bus.core_halted) state_nx = DRAIN;
      DRAIN:   state_nx = EXT;
      EXT:     if (!bus.core_halted) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // Grant decision: no grant on the cycle a mode change is taken.
  always_comb begin
    gnt_nx = P_NONE;
    case (state)
      RUN: begin
        if (!bus.core_halted) begin
          if (pick[1]) begin
            gnt_nx = P_DM;
          end else if (pick[0]) begin
            gnt_nx = P_IF;
          end
        end
      end
      EXT: begin
        if (bus.core_halted && bus.ext_req) begin
          gnt_nx = P_EXT;
        end
      end
      default: gnt_nx = P_NONE;
    endcase
  end

  // Counts consecutive RUN cycles in which fetch asked and lost; saturates.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state != RUN || !bus.if_req || gnt_nx == P_IF) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registers the granted access onto the memory bus for one cycle.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      gnt_port    <= P_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      gnt_port <= gnt_nx;
      case (gnt_nx)
        P_DM: begin
          mem_we_q    <= bus.dm_we;
          mem_addr_q  <= bus.dm_addr;
          mem_wdata_q <= bus.dm_wdata;
        end
        P_IF: begin
          mem_we_q   <= 1'b0;
          mem_addr_q <= bus.if_addr;
        end
        P_EXT: begin
          mem_we_q    <= bus.ext_we;
          mem_addr_q  <= bus.ext_addr;
          mem_wdata_q <= bus.ext_wdata;
        end
        default: mem_we_q <= 1'b0;
      endcase
    end
  end

  // Remembers who owns the read now in the memory so its data is routed back next cycle.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      rd_tag <= P_NONE;
    end else if (gnt_port != P_NONE && !mem_we_q) begin
      rd_tag <= gnt_port;
    end else begin
      rd_tag <= P_NONE;
    end
  end

  assign bus.dm_gnt     = (gnt_port == P_DM);
  assign bus.if_gnt     = (gnt_port == P_IF);
  assign bus.ext_gnt    = (gnt_port == P_EXT);
  assign bus.mem_en     = (gnt_port != P_NONE);
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.dm_rvalid  = (rd_tag == P_DM);
  assign bus.if_rvalid  = (rd_tag == P_IF);
  assign bus.ext_rvalid = (rd_tag == P_EXT);
  assign bus.rdata      = (rd_tag != P_NONE) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mips_pkg::*;

  localparam int SM = 3;

  logic clk1 = 1'b0;
  logic rst_n;
  always #5 clk1 = ~clk1;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous-read memory array plus a backdoor loader used only while the port is idle.
  logic [31:0] mem [1024];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk1) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata    <= mem[bus.mem_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] oh(input port_id_t p);
    case (p)
      P_DM:    return 3'b001;
      P_IF:    return 3'b010;
      P_EXT:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] gnts();
    return {bus.ext_gnt, bus.if_gnt, bus.dm_gnt};
  endfunction

  function automatic logic [2:0] rvs();
    return {bus.ext_rvalid, bus.if_rvalid, bus.dm_rvalid};
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.core_halted = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
  endtask

  // Single-shot arbitration vectors, each applied from an idle RUN state.
  typedef struct {
    logic        dm_req;
    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        if_req;
    logic [9:0]  if_addr;
    port_id_t    exp_gnt;
    logic        exp_we;
    port_id_t    exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vt[6];

  // Reference model: tracks the halt mode, fetch losses and the memory image.
  int          m_mode;        // 0 running, 1 draining, 2 loader
  int          m_lost;
  port_id_t    m_pend;
  logic [31:0] m_pend_data;
  logic [31:0] ref_mem [16];
  port_id_t    exp_g, exp_rv;
  logic [31:0] exp_rd;
  logic        exp_we;
  logic [9:0]  exp_addr;
  logic [31:0] exp_wd;

  task automatic model_step();
    exp_rv = m_pend;
    exp_rd = m_pend_data;
    exp_g  = P_NONE;
    if (m_mode == 0) begin
      if (bus.core_halted)                  m_mode = 1;
      else if (bus.if_req && m_lost >= SM)  exp_g = P_IF;
      else if (bus.dm_req)                  exp_g = P_DM;
      else if (bus.if_req)                  exp_g = P_IF;
      if (bus.if_req && exp_g != P_IF) m_lost = (m_lost < SM) ? m_lost + 1 : SM;
      else                             m_lost = 0;
    end else if (m_mode == 1) begin
      m_mode = 2;
      m_lost = 0;
    end else begin
      m_lost = 0;
      if (!bus.core_halted)  m_mode = 0;
      else if (bus.ext_req)  exp_g = P_EXT;
    end
    exp_we = 1'b0; exp_addr = '0; exp_wd = '0; m_pend = P_NONE;
    case (exp_g)
      P_DM:    begin exp_we = bus.dm_we;  exp_addr = bus.dm_addr;  exp_wd = bus.dm_wdata;  end
      P_IF:    begin exp_addr = bus.if_addr; end
      P_EXT:   begin exp_we = bus.ext_we; exp_addr = bus.ext_addr; exp_wd = bus.ext_wdata; end
      default: ;
    endcase
    if (exp_g != P_NONE) begin
      if (exp_we) ref_mem[exp_addr[3:0]] = exp_wd;
      else begin
        m_pend      = exp_g;
        m_pend_data = ref_mem[exp_addr[3:0]];
      end
    end
  endtask

  initial begin
    logic dm_p, if_p, ext_p;
    port_id_t seq3 [5];
    vt[0] = '{1'b1, 1'b0, 10'd5, 32'h0,  1'b0, 10'd0, P_DM,   1'b0, P_DM,   32'h11};
    vt[1] = '{1'b0, 1'b0, 10'd0, 32'h0,  1'b1, 10'd7, P_IF,   1'b0, P_IF,   32'h22};
    vt[2] = '{1'b1, 1'b0, 10'd7, 32'h0,  1'b1, 10'd5, P_DM,   1'b0, P_DM,   32'h22};
    vt[3] = '{1'b0, 1'b0, 10'd0, 32'h0,  1'b0, 10'd0, P_NONE, 1'b0, P_NONE, 32'h0};
    vt[4] = '{1'b1, 1'b1, 10'd9, 32'h99, 1'b0, 10'd0, P_DM,   1'b1, P_NONE, 32'h0};
    vt[5] = '{1'b0, 1'b0, 10'd0, 32'h0,  1'b1, 10'd9, P_IF,   1'b0, P_IF,   32'h99};
    seq3 = '{P_DM, P_DM, P_DM, P_IF, P_DM};

    // Preload while held in reset.
    rst_n = 1'b0;
    idle_inputs();
    bd_write(10'd1, 32'hA1);
    bd_write(10'd5, 32'h11);
    bd_write(10'd7, 32'h22);

    // 1: reset with every request high.
    bus.dm_req = 1'b1; bus.dm_addr = 10'd1; bus.if_req = 1'b1; bus.if_addr = 10'd2; bus.ext_req = 1'b1;
    tick(); tick();
    chk("rst_gnt", gnts(), 3'b000);
    chk("rst_rvalid", rvs(), 3'b000);
    chk("rst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata}, '0);
    rst_n = 1'b1;
    tick();
    chk("rst_first_gnt", gnts(), oh(P_DM));
    idle_inputs();
    tick();
    chk("rst_first_rv", rvs(), oh(P_DM));
    chk("rst_first_rdata", bus.rdata, 32'hA1);
    tick();

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      bus.dm_req = vt[i].dm_req; bus.dm_we = vt[i].dm_we;
      bus.dm_addr = vt[i].dm_addr; bus.dm_wdata = vt[i].dm_wdata;
      bus.if_req = vt[i].if_req; bus.if_addr = vt[i].if_addr;
      tick();
      chk($sformatf("vec%0d_gnt", i), gnts(), oh(vt[i].exp_gnt));
      chk($sformatf("vec%0d_we", i), bus.mem_we, vt[i].exp_we);
      idle_inputs();
      tick();
      chk($sformatf("vec%0d_rv", i), rvs(), oh(vt[i].exp_rv));
      if (vt[i].exp_rv != P_NONE) chk($sformatf("vec%0d_rdata", i), bus.rdata, vt[i].exp_rdata);
    end

    // 2: dm and fetch together; dm first, fetch next, data in order.
    bus.dm_req = 1'b1; bus.dm_addr = 10'd5; bus.if_req = 1'b1; bus.if_addr = 10'd7;
    tick();
    chk("t2_gnt0", gnts(), oh(P_DM));
    bus.dm_req = 1'b0;
    tick();
    chk("t2_gnt1", gnts(), oh(P_IF));
    chk("t2_rv1", rvs(), oh(P_DM));
    chk("t2_rd1", bus.rdata, 32'h11);
    bus.if_req = 1'b0;
    tick();
    chk("t2_gnt2", gnts(), 3'b000);
    chk("t2_rv2", rvs(), oh(P_IF));
    chk("t2_rd2", bus.rdata, 32'h22);
    tick();

    // 3: dm re-requests every cycle; fetch breaks through after STARVE_MAX losses.
    bus.dm_req = 1'b1; bus.dm_addr = 10'd5; bus.if_req = 1'b1; bus.if_addr = 10'd7;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t3_gnt%0d", k), gnts(), oh(seq3[k]));
      if (k == 4) begin
        chk("t3_if_rv", rvs(), oh(P_IF));
        chk("t3_if_rd", bus.rdata, 32'h22);
      end
      if (gnts() == 3'b010) bus.if_req = 1'b0;
    end
    idle_inputs();
    tick(); tick();

    // 4: halt with a dm load in flight, then loader store and load.
    bus.dm_req = 1'b1; bus.dm_addr = 10'd5; bus.if_req = 1'b1; bus.if_addr = 10'd7;
    tick();
    chk("t4_dm_gnt", gnts(), oh(P_DM));
    bus.dm_req = 1'b0; bus.core_halted = 1'b1;
    tick();
    chk("t4_halt_gnt", gnts(), 3'b000);
    chk("t4_dm_rv", rvs(), oh(P_DM));
    chk("t4_dm_rd", bus.rdata, 32'h11);
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 10'h3FF; bus.ext_wdata = 32'hDEADBEEF;
    tick();
    chk("t4_drain_gnt", gnts(), 3'b000);
    tick();
    chk("t4_ext_wr_gnt", gnts(), oh(P_EXT));
    chk("t4_ext_wr_mem", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 10'h3FF, 32'hDEADBEEF});
    bus.ext_we = 1'b0;
    tick();
    chk("t4_ext_rd_gnt", gnts(), oh(P_EXT));
    chk("t4_ext_rd_rv", rvs(), 3'b000);
    bus.ext_req = 1'b0;
    tick();
    chk("t4_ext_rv", {gnts(), rvs()}, {3'b000, oh(P_EXT)});
    chk("t4_ext_rd", bus.rdata, 32'hDEADBEEF);

    // 5: un-halt while the loader still requests; fetch served right after.
    bus.ext_req = 1'b1;
    bus.core_halted = 1'b0;
    tick();
    chk("t5_switch_gnt", gnts(), 3'b000);
    tick();
    chk("t5_if_gnt", gnts(), oh(P_IF));
    bus.if_req = 1'b0; bus.ext_req = 1'b0;
    tick();
    chk("t5_if_rv", rvs(), oh(P_IF));
    chk("t5_if_rd", bus.rdata, 32'h22);
    tick();

    // 6: reset lands right after a loader read is granted.
    bus.core_halted = 1'b1; bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 10'd5;
    tick(); tick();
    tick();
    chk("t6_ext_gnt", gnts(), oh(P_EXT));
    rst_n = 1'b0;
    idle_inputs();
    tick();
    chk("t6_rst_rv", rvs(), 3'b000);
    chk("t6_rst_state", 64'(dut.state), 64'(RUN));
    chk("t6_rst_starve", 64'(dut.starve_cnt), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_no_late_rv", rvs(), 3'b000);

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom;
      bd_write(10'(i), v);
      ref_mem[i] = v;
    end
    m_mode = 0; m_lost = 0; m_pend = P_NONE; m_pend_data = '0;
    dm_p = 1'b0; if_p = 1'b0; ext_p = 1'b0;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!dm_p && $urandom_range(0, 3) != 0) begin
        dm_p = 1'b1; bus.dm_we = 1'($urandom_range(0, 1));
        bus.dm_addr = 10'($urandom_range(0, 15)); bus.dm_wdata = $urandom;
      end
      if (!if_p && $urandom_range(0, 1) != 0) begin
        if_p = 1'b1; bus.if_addr = 10'($urandom_range(0, 15));
      end
      if (!ext_p && $urandom_range(0, 1) != 0) begin
        ext_p = 1'b1; bus.ext_we = 1'($urandom_range(0, 1));
        bus.ext_addr = 10'($urandom_range(0, 15)); bus.ext_wdata = $urandom;
      end
      bus.dm_req = dm_p; bus.if_req = if_p; bus.ext_req = ext_p;
      if ($urandom_range(0, 39) == 0) bus.core_halted = ~bus.core_halted;
      model_step();
      tick();
      chk("rnd_gnt", gnts(), oh(exp_g));
      chk("rnd_rvalid", rvs(), oh(exp_rv));
      if (exp_rv != P_NONE) chk("rnd_rdata", bus.rdata, exp_rd);
      if (exp_g != P_NONE)
        chk("rnd_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, (bus.mem_we ? bus.mem_wdata : 32'h0)},
                       {1'b1, exp_we, exp_addr, (exp_we ? exp_wd : 32'h0)});
      else
        chk("rnd_mem_idle", bus.mem_en, 1'b0);
      if (bus.dm_gnt)  dm_p  = 1'b0;
      if (bus.if_gnt)  if_p  = 1'b0;
      if (bus.ext_gnt) ext_p = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
